// File: rtl/round_judge_if.sv
// Signal bundle between the symbol-match round judge and the rest of the game:
// button/tick/pattern inputs in, match/score/lives/status outputs back.
interface round_judge_if;
    logic       tick_1s;
    logic       start_n;
    logic       submit_n;
    logic [5:0] target;
    logic [5:0] guess;
    logic       next_pattern;
    logic       round_active;
    logic       result_valid;
    logic [2:0] match;
    logic [3:0] time_left;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
    logic [1:0] lives;
    logic       game_over;
    logic [2:0] state_dbg;

    // result_valid is a level with no ready: match/score/lives are stable and
    // meaningful for every cycle it is high; there is no backpressure.
    modport master (
        output tick_1s, start_n, submit_n, target, guess,
        input  next_pattern, round_active, result_valid, match, time_left,
               score_tens, score_ones, lives, game_over, state_dbg
    );

    modport slave (
        input  tick_1s, start_n, submit_n, target, guess,
        output next_pattern, round_active, result_valid, match, time_left,
               score_tens, score_ones, lives, game_over, state_dbg
    );
endinterface

// File: rtl/round_judge.sv
// Player-response side of the symbol-match game: arms a timed round, judges the
// switch guesses against the latched targets, and keeps BCD score and lives.
module round_judge #(
    parameter int ROUND_SECONDS = 9,
    parameter int SHOW_SECONDS  = 2,
    parameter int LIVES         = 3
) (
    input  logic         clk,
    input  logic         clear_b,
    round_judge_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARMED,
        S_JUDGE,
        S_SHOW,
        S_OVER
    } state_t;

    localparam logic [3:0] ROUND_INIT = 4'(ROUND_SECONDS);
    localparam logic [3:0] SHOW_INIT  = 4'(SHOW_SECONDS);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    state_t     state_q, state_d;
    logic [2:0] start_sync_q, start_sync_d;
    logic [2:0] submit_sync_q, submit_sync_d;
    logic       start_evt_q, start_evt_d;
    logic       submit_evt_q, submit_evt_d;
    logic [5:0] tgt_q, tgt_d;
    logic [5:0] gss_q, gss_d;
    logic [3:0] time_q, time_d;
    logic       timeout_q, timeout_d;
    logic [3:0] show_q, show_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [1:0] lives_q, lives_d;
    logic [2:0] match_q, match_d;
    logic [2:0] match_calc;
    logic       next_pattern_q, next_pattern_d;
    logic       round_active_q, round_active_d;
    logic       result_valid_q, result_valid_d;
    logic       game_over_q, game_over_d;

    always_comb begin
        // sync[0] is the metastable stage, sync[1] the synchronized level,
        // sync[2] its previous value; a press is the falling edge of sync[1].
        start_sync_d  = {start_sync_q[1:0], bus.start_n};
        submit_sync_d = {submit_sync_q[1:0], bus.submit_n};
        start_evt_d   = start_sync_q[2] & ~start_sync_q[1];
        submit_evt_d  = submit_sync_q[2] & ~submit_sync_q[1];

        match_calc = '0;
        for (int i = 0; i < 3; i++) begin
            match_calc[i] = (gss_q[2*i +: 2] == tgt_q[2*i +: 2]) &&
                            (gss_q[2*i +: 2] != 2'd3);
        end

        state_d   = state_q;
        tgt_d     = tgt_q;
        gss_d     = gss_q;
        time_d    = time_q;
        timeout_d = timeout_q;
        show_d    = show_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        lives_d   = lives_q;
        match_d   = match_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_evt_q) begin
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    lives_d = LIVES_INIT;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                tgt_d   = bus.target;
                time_d  = ROUND_INIT;
                match_d = 3'b000;
                state_d = S_ARMED;
            end
            S_ARMED: begin
                if (submit_evt_q) begin
                    gss_d   = bus.guess;
                    state_d = S_JUDGE;
                end else if (bus.tick_1s) begin
                    time_d = time_q - 4'd1;
                    if (time_q == 4'd1) begin
                        timeout_d = 1'b1;
                        state_d   = S_JUDGE;
                    end
                end
            end
            S_JUDGE: begin
                match_d = timeout_q ? 3'b000 : match_calc;
                if (match_d == 3'b111) begin
                    // BCD increment that saturates at 99
                    if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
                        if (ones_q == 4'd9) begin
                            ones_d = 4'd0;
                            tens_d = tens_q + 4'd1;
                        end else begin
                            ones_d = ones_q + 4'd1;
                        end
                    end
                end else if (lives_q != 2'd0) begin
                    lives_d = lives_q - 2'd1;
                end
                timeout_d = 1'b0;
                show_d    = SHOW_INIT;
                state_d   = S_SHOW;
            end
            S_SHOW: begin
                if (bus.tick_1s) begin
                    show_d = show_q - 4'd1;
                    if (show_q == 4'd1) begin
                        state_d = (lives_q == 2'd0) ? S_OVER : S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        next_pattern_d = (state_d == S_LOAD);
        round_active_d = (state_d == S_ARMED);
        result_valid_d = (state_d == S_SHOW);
        game_over_d    = (state_d == S_OVER);
    end

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            state_q        <= S_IDLE;
            start_sync_q   <= 3'b111;
            submit_sync_q  <= 3'b111;
            start_evt_q    <= 1'b0;
            submit_evt_q   <= 1'b0;
            tgt_q          <= 6'd0;
            gss_q          <= 6'd0;
            time_q         <= 4'd0;
            timeout_q      <= 1'b0;
            show_q         <= 4'd0;
            tens_q         <= 4'd0;
            ones_q         <= 4'd0;
            lives_q        <= LIVES_INIT;
            match_q        <= 3'b000;
            next_pattern_q <= 1'b0;
            round_active_q <= 1'b0;
            result_valid_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_sync_q   <= start_sync_d;
            submit_sync_q  <= submit_sync_d;
            start_evt_q    <= start_evt_d;
            submit_evt_q   <= submit_evt_d;
            tgt_q          <= tgt_d;
            gss_q          <= gss_d;
            time_q         <= time_d;
            timeout_q      <= timeout_d;
            show_q         <= show_d;
            tens_q         <= tens_d;
            ones_q         <= ones_d;
            lives_q        <= lives_d;
            match_q        <= match_d;
            next_pattern_q <= next_pattern_d;
            round_active_q <= round_active_d;
            result_valid_q <= result_valid_d;
            game_over_q    <= game_over_d;
        end
    end

    assign bus.next_pattern = next_pattern_q;
    assign bus.round_active = round_active_q;
    assign bus.result_valid = result_valid_q;
    assign bus.match        = match_q;
    assign bus.time_left    = time_q;
    assign bus.score_tens   = tens_q;
    assign bus.score_ones   = ones_q;
    assign bus.lives        = lives_q;
    assign bus.game_over    = game_over_q;
    assign bus.state_dbg    = state_q;

endmodule
